// File: rtl/xadc_multichannel_averager.sv
// Multi-channel XADC readout: DRP master to the XADC wizard in continuous
// sequencer mode. Each end-of-conversion on one of NUM_CH consecutive VAUX
// channels triggers a DRP read. The 12-bit code goes into a per-channel
// 2**AVG_LOG2 running average. The average of ch_sel is converted to TMP36
// degC*10 and degF*10.
// Ports:
//   clk, reset_n            clock (also XADC dclk), synchronous active-low reset
//   eoc_in, channel_in      XADC end-of-conversion strobe and converted channel
//   drp_daddr, drp_den      DRP read request (dwe tied low outside this block)
//   drp_drdy, drp_do        DRP read response, code in drp_do[15:4]
//   ch_sel                  channel shown on the temperature outputs
//   clr_err                 clears the sticky overrun / timeout_err flags
//   celsius_x10, fahrenheit_x10, sample_valid   display path outputs
//   busy, overrun, timeout_err                  status
module xadc_multichannel_averager #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned AUX_FIRST   = 5,
  parameter int unsigned AVG_LOG2    = 4,
  parameter int unsigned DRP_TIMEOUT = 63,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              eoc_in,
  input  logic [4:0]        channel_in,
  output logic [6:0]        drp_daddr,
  output logic              drp_den,
  input  logic              drp_drdy,
  input  logic [15:0]       drp_do,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              clr_err,
  output logic [15:0]       celsius_x10,
  output logic [15:0]       fahrenheit_x10,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned SMP_W   = 12;
  localparam int unsigned ACC_W   = SMP_W + AVG_LOG2;
  localparam int unsigned CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned CNT_MAX = (1 << AVG_LOG2) - 1;
  localparam int unsigned TMR_W   = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT + 1) : 1;
  localparam int unsigned CH_LO   = 16 + AUX_FIRST;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACC} state_e;

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          kidx_q, kidx_d;
  logic [6:0]               daddr_q, daddr_d;
  logic                     den_q, den_d;
  logic                     busy_q, busy_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [SMP_W-1:0]         smp_q, smp_d;
  logic [ACC_W-1:0]         acc_q [NUM_CH];
  logic [ACC_W-1:0]         acc_d [NUM_CH];
  logic [CNT_W-1:0]         cnt_q [NUM_CH];
  logic [CNT_W-1:0]         cnt_d [NUM_CH];
  logic [SMP_W-1:0]         avg_q [NUM_CH];
  logic [SMP_W-1:0]         avg_d [NUM_CH];
  logic                     upd_q, upd_d;
  logic                     ovr_q, ovr_d;
  logic                     tmo_q, tmo_d;
  logic signed [15:0]       c1_q, c1_d;
  logic                     v1_q, v1_d;
  logic signed [15:0]       cel_q, cel_d;
  logic signed [15:0]       fah_q, fah_d;
  logic                     sv_q, sv_d;

  logic [6:0]               ch_ext;
  logic                     in_range;
  logic [ACC_W-1:0]         acc_sum;
  logic                     wrap;
  logic                     ovr_set;
  logic                     tmo_set;
  logic [SMP_W-1:0]         avg_sel;
  logic [21:0]              prod;
  logic [9:0]               mv;
  logic                     unused_drp_lsb;

  // Low nibble of the DRP word carries no conversion data.
  assign unused_drp_lsb = ^drp_do[3:0];

  assign ch_ext   = {2'b00, channel_in};
  assign in_range = (ch_ext >= 7'(CH_LO)) && (ch_ext < 7'(CH_LO + NUM_CH));

  // Read FSM, per-channel accumulators and sticky status flags.
  always_comb begin
    state_d = state_q;
    kidx_d  = kidx_q;
    daddr_d = daddr_q;
    tmr_d   = tmr_q;
    smp_d   = smp_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    upd_d   = 1'b0;
    acc_sum = '0;
    wrap    = 1'b0;
    ovr_set = 1'b0;
    tmo_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (eoc_in && in_range) begin
          kidx_d  = CH_W'(ch_ext - 7'(CH_LO));
          daddr_d = ch_ext;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (drp_drdy) begin
          smp_d   = drp_do[15:4];
          state_d = S_ACC;
        end else if (tmr_q == TMR_W'(DRP_TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_ACC: begin
        acc_sum = acc_q[kidx_q] + ACC_W'(smp_q);
        wrap    = (cnt_q[kidx_q] == CNT_W'(CNT_MAX));
        if (wrap) begin
          cnt_d[kidx_q] = '0;
          acc_d[kidx_q] = '0;
          avg_d[kidx_q] = SMP_W'(acc_sum >> AVG_LOG2);
          upd_d         = (kidx_q == ch_sel);
        end else begin
          cnt_d[kidx_q] = cnt_q[kidx_q] + 1'b1;
          acc_d[kidx_q] = acc_sum;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A conversion finishing while a read is in flight is lost.
    if (eoc_in && (state_q != S_IDLE)) begin
      ovr_set = 1'b1;
    end

    ovr_d  = clr_err ? 1'b0 : (ovr_q | ovr_set);
    tmo_d  = clr_err ? 1'b0 : (tmo_q | tmo_set);
    den_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
  end

  // Two-stage TMP36 conversion of the selected channel's average.
  always_comb begin
    avg_sel = '0;
    if ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH)) begin
      avg_sel = avg_q[ch_sel];
    end
    prod  = 22'(avg_sel) * 22'd1000;
    mv    = 10'(prod >> 12);
    c1_d  = $signed({6'b000000, mv}) - 16'sd500;
    v1_d  = upd_q;
    cel_d = c1_q;
    // Signed divide truncates toward zero.
    fah_d = (c1_q * 16'sd9) / 16'sd5 + 16'sd320;
    sv_d  = v1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      kidx_q  <= '0;
      daddr_q <= '0;
      den_q   <= 1'b0;
      busy_q  <= 1'b0;
      tmr_q   <= '0;
      smp_q   <= '0;
      acc_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      avg_q   <= '{default: '0};
      upd_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      c1_q    <= '0;
      v1_q    <= 1'b0;
      cel_q   <= '0;
      fah_q   <= '0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kidx_q  <= kidx_d;
      daddr_q <= daddr_d;
      den_q   <= den_d;
      busy_q  <= busy_d;
      tmr_q   <= tmr_d;
      smp_q   <= smp_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      upd_q   <= upd_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      c1_q    <= c1_d;
      v1_q    <= v1_d;
      cel_q   <= cel_d;
      fah_q   <= fah_d;
      sv_q    <= sv_d;
    end
  end

  assign drp_daddr      = daddr_q;
  assign drp_den        = den_q;
  assign busy           = busy_q;
  assign overrun        = ovr_q;
  assign timeout_err    = tmo_q;
  assign celsius_x10    = cel_q;
  assign fahrenheit_x10 = fah_q;
  assign sample_valid   = sv_q;

endmodule

// File: tb/tb_xadc_multichannel_averager.sv
// Directed bench for xadc_multichannel_averager (NUM_CH=4, AUX_FIRST=5,
// AVG_LOG2=2, DRP_TIMEOUT=63). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_xadc_multichannel_averager;

  localparam int unsigned CH_W = 2;

  logic            clk;
  logic            reset_n;
  logic            eoc_in;
  logic [4:0]      channel_in;
  logic [6:0]      drp_daddr;
  logic            drp_den;
  logic            drp_drdy;
  logic [15:0]     drp_do;
  logic [CH_W-1:0] ch_sel;
  logic            clr_err;
  logic [15:0]     celsius_x10;
  logic [15:0]     fahrenheit_x10;
  logic            sample_valid;
  logic            busy;
  logic            overrun;
  logic            timeout_err;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;
  int v0       = 0;
  logic signed [31:0] last_c = 0;
  logic signed [31:0] last_f = 0;

  xadc_multichannel_averager #(
    .NUM_CH(4), .AUX_FIRST(5), .AVG_LOG2(2), .DRP_TIMEOUT(63)
  ) dut (
    .clk(clk), .reset_n(reset_n), .eoc_in(eoc_in), .channel_in(channel_in),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_drdy(drp_drdy), .drp_do(drp_do),
    .ch_sel(ch_sel), .clr_err(clr_err), .celsius_x10(celsius_x10),
    .fahrenheit_x10(fahrenheit_x10), .sample_valid(sample_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge and record any sample_valid pulse.
  task automatic step();
    @(negedge clk);
    if (sample_valid === 1'b1) begin
      vcount++;
      last_c = $signed(celsius_x10);
      last_f = $signed(fahrenheit_x10);
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One complete DRP read; optionally pulse eoc_in together with drdy.
  task automatic do_read(input logic [4:0] ch, input logic [15:0] d, input bit eoc_wait);
    channel_in = ch;
    eoc_in     = 1'b1;
    step();
    eoc_in = 1'b0;
    chk("rd_den_pulse", drp_den, 1);
    chk("rd_daddr", {2'b00, ch}, drp_daddr);
    step();
    chk("rd_den_drop", drp_den, 0);
    drp_drdy = 1'b1;
    drp_do   = d;
    if (eoc_wait) eoc_in = 1'b1;
    step();
    drp_drdy = 1'b0;
    eoc_in   = 1'b0;
    step();
  endtask

  initial begin
    reset_n    = 1'b0;
    eoc_in     = 1'b0;
    channel_in = '0;
    drp_drdy   = 1'b0;
    drp_do     = '0;
    ch_sel     = '0;
    clr_err    = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_den", drp_den, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cel", $signed(celsius_x10), 0);
    chk("rst_fah", $signed(fahrenheit_x10), 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_tmo", timeout_err, 0);
    reset_n = 1'b1;
    repeat (3) step();
    chk("post_rst_cel", $signed(celsius_x10), -500);
    chk("post_rst_fah", $signed(fahrenheit_x10), -580);
    chk("post_rst_novalid", vcount, 0);

    // Reset while waiting on DRP, with overrun set and drdy pending
    channel_in = 5'h15;
    eoc_in     = 1'b1;
    step();
    eoc_in = 1'b0;
    chk("t1_den", drp_den, 1);
    step();
    eoc_in = 1'b1;
    step();
    eoc_in = 1'b0;
    chk("t1_ovr_set", overrun, 1);
    chk("t1_busy_wait", busy, 1);
    reset_n  = 1'b0;
    drp_drdy = 1'b1;
    drp_do   = 16'hFFF0;
    step();
    chk("t1_rst_den", drp_den, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_ovr", overrun, 0);
    chk("t1_rst_tmo", timeout_err, 0);
    chk("t1_rst_cel", $signed(celsius_x10), 0);
    chk("t1_rst_fah", $signed(fahrenheit_x10), 0);
    reset_n = 1'b1;
    step();
    drp_drdy = 1'b0;
    chk("t1_late_drdy_idle", busy, 0);
    repeat (3) step();
    chk("t1_cel", $signed(celsius_x10), -500);
    chk("t1_fah", $signed(fahrenheit_x10), -580);
    chk("t1_novalid", vcount, 0);

    // Mid-scale average on channel 0x15
    v0 = vcount;
    repeat (3) do_read(5'h15, 16'h8000, 1'b0);
    repeat (3) step();
    chk("t2_no_early_valid", vcount - v0, 0);
    do_read(5'h15, 16'h8000, 1'b0);
    repeat (3) step();
    chk("t2_valid_cnt", vcount - v0, 1);
    chk("t2_cel", last_c, 0);
    chk("t2_fah", last_f, 320);

    // Full scale, then truncation of a small sum
    v0 = vcount;
    repeat (4) do_read(5'h15, 16'hFFF0, 1'b0);
    repeat (3) step();
    chk("t3_fs_valid_cnt", vcount - v0, 1);
    chk("t3_fs_cel", last_c, 499);
    chk("t3_fs_fah", last_f, 1218);
    v0 = vcount;
    do_read(5'h15, 16'h0000, 1'b0);
    repeat (3) do_read(5'h15, 16'h0010, 1'b0);
    repeat (3) step();
    chk("t3_tr_valid_cnt", vcount - v0, 1);
    chk("t3_tr_cel", last_c, -500);
    chk("t3_tr_fah", last_f, -580);

    // Out-of-window channels
    v0 = vcount;
    channel_in = 5'h03; eoc_in = 1'b1; step(); eoc_in = 1'b0;
    chk("t6_ch03_den", drp_den, 0);
    chk("t6_ch03_busy", busy, 0);
    channel_in = 5'h19; eoc_in = 1'b1; step(); eoc_in = 1'b0;
    chk("t6_ch19_den", drp_den, 0);
    channel_in = 5'h14; eoc_in = 1'b1; step(); eoc_in = 1'b0;
    chk("t6_ch14_den", drp_den, 0);
    chk("t6_idle_no_ovr", overrun, 0);

    // Overrun from eoc together with drdy; the sample still counts
    do_read(5'h16, 16'h4000, 1'b1);
    chk("t4_ovr_set", overrun, 1);
    repeat (3) step();
    chk("t4_ovr_held", overrun, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t4_ovr_clr", overrun, 0);

    do_read(5'h15, 16'hFFF0, 1'b0);

    // DRP timeout on channel 0x16
    channel_in = 5'h16;
    eoc_in     = 1'b1;
    step();
    eoc_in = 1'b0;
    chk("t5_den", drp_den, 1);
    repeat (63) step();
    chk("t5_busy_62", busy, 1);
    chk("t5_tmo_62", timeout_err, 0);
    step();
    chk("t5_busy_63", busy, 0);
    chk("t5_tmo_63", timeout_err, 1);
    repeat (2) step();
    chk("t5_tmo_held", timeout_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t5_tmo_clr", timeout_err, 0);

    // Interleaved channels 0x15 / 0x16
    do_read(5'h15, 16'hFFF0, 1'b0);
    do_read(5'h16, 16'h4000, 1'b0);
    do_read(5'h15, 16'hFFF0, 1'b0);
    do_read(5'h16, 16'h4000, 1'b0);
    do_read(5'h15, 16'hFFF0, 1'b0);
    do_read(5'h16, 16'h4000, 1'b0);
    repeat (3) step();
    chk("t6_valid_cnt", vcount - v0, 1);
    chk("t6_ch0_cel", last_c, 499);
    chk("t6_ch0_fah", last_f, 1218);

    // Channel select switching
    v0 = vcount;
    ch_sel = 2'd1;
    step();
    chk("t6_sel1_lag", $signed(celsius_x10), 499);
    step();
    chk("t6_sel1_cel", $signed(celsius_x10), -250);
    chk("t6_sel1_fah", $signed(fahrenheit_x10), -130);
    ch_sel = 2'd0;
    repeat (2) step();
    chk("t6_sel0_cel", $signed(celsius_x10), 499);
    chk("t6_sel0_fah", $signed(fahrenheit_x10), 1218);
    chk("t6_sel_novalid", vcount - v0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
